// File: rtl/gpu_rect_engine.sv
// gpu_rect_engine: double-buffered rectangle rasteriser.
// Rect records stream into a back bank; the rendered bank is swapped at a
// frame boundary; each pixel returns the color of the highest-index covering
// rect through a fixed 2-cycle pipeline.
// Build option: define GPU_DOUBLE_BUFFER_EN for two banks with frame-boundary
// swap; when undefined a single bank is written and rendered directly.
module gpu_rect_engine #(
  parameter int unsigned COORD_WIDTH   = 16,
  parameter int unsigned RECT_COUNT    = 64,
  parameter int unsigned IDX_WIDTH     = $clog2(RECT_COUNT),
  parameter logic [15:0] DEFAULT_COLOR = 16'h0000
) (
  input  logic                   pixel_clk,
  input  logic                   reset,
  input  logic                   copy_start,
  input  logic                   din_valid,
  input  logic [15:0]            din,
  input  logic                   frame_start,
  input  logic                   coord_valid,
  input  logic [COORD_WIDTH-1:0] x_coord,
  input  logic [COORD_WIDTH-1:0] y_coord,
  output logic [15:0]            color,
  output logic                   color_valid,
  output logic                   busy,
  output logic                   swap_pending,
  output logic                   active_bank
);

  localparam int unsigned WORDS_PER_RECT = 5;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_COPY = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2:0]             r_word;
  logic [IDX_WIDTH-1:0]   r_rect;
  logic                   r_active;
  logic                   r_swap_pending;
  logic [1:0]             r_bank_loaded;

  logic                   w_busy;
  logic                   w_wr_en;
  logic                   w_load_start;
  logic                   w_last;
  logic                   w_last_word;
  logic                   w_swap;
  logic                   w_back;
  logic                   w_set_pending;

  // Bank storage (never reset; validity tracked by r_bank_loaded)
  logic [COORD_WIDTH-1:0] r_left   [2][RECT_COUNT];
  logic [COORD_WIDTH-1:0] r_top    [2][RECT_COUNT];
  logic [COORD_WIDTH-1:0] r_right  [2][RECT_COUNT];
  logic [COORD_WIDTH-1:0] r_bottom [2][RECT_COUNT];
  logic [15:0]            r_cmem   [2][RECT_COUNT];

  logic [COORD_WIDTH-1:0] w_din_coord;
  logic [COORD_WIDTH:0]   w_sum_r;
  logic [COORD_WIDTH:0]   w_sum_b;
  logic [COORD_WIDTH-1:0] w_sat_right;
  logic [COORD_WIDTH-1:0] w_sat_bottom;

  logic [RECT_COUNT-1:0]  w_hit;
  logic [RECT_COUNT-1:0]  r_hit_s1;
  logic                   r_bank_s1;
  logic                   r_valid_s1;
  logic                   w_found;
  logic [IDX_WIDTH-1:0]   w_idx;
  logic [15:0]            w_pix_color;
  logic [15:0]            r_color;
  logic                   r_color_valid;

`ifdef GPU_DOUBLE_BUFFER_EN
  assign w_back        = ~r_active;
  assign w_set_pending = 1'b1;
`else
  assign w_back        = r_active;
  assign w_set_pending = 1'b0;
`endif

  assign w_last_word = (r_word == 3'(WORDS_PER_RECT - 1)) &&
                       (r_rect == IDX_WIDTH'(RECT_COUNT - 1));
  assign w_swap      = frame_start & r_swap_pending & ~w_busy;

  // Copy FSM state register
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Copy FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (copy_start) w_state_nxt = S_COPY;
      S_COPY:  if (din_valid && w_last_word) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Copy FSM output decode
  always_comb begin
    w_busy       = 1'b0;
    w_wr_en      = 1'b0;
    w_load_start = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      S_IDLE: w_load_start = copy_start;
      S_COPY: begin
        w_busy  = 1'b1;
        w_wr_en = din_valid;
        w_last  = din_valid & w_last_word;
      end
      default: ;
    endcase
  end

  // Word / rect counters walk the record stream
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      r_word <= '0;
      r_rect <= '0;
    end else if (w_load_start) begin
      r_word <= '0;
      r_rect <= '0;
    end else if (w_wr_en) begin
      if (r_word == 3'(WORDS_PER_RECT - 1)) begin
        r_word <= '0;
        r_rect <= r_rect + IDX_WIDTH'(1);
      end else begin
        r_word <= r_word + 3'd1;
      end
    end
  end

  // Bank selection, swap handshake and per-bank loaded flags
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      r_active       <= 1'b0;
      r_swap_pending <= 1'b0;
      r_bank_loaded  <= '0;
    end else begin
      if (w_swap) r_active <= ~r_active;
      if (w_last) begin
        r_swap_pending        <= w_set_pending;
        r_bank_loaded[w_back] <= 1'b1;
      end else if (w_swap || w_load_start) begin
        r_swap_pending <= 1'b0;
      end
    end
  end

  // Right/bottom edges stored as saturated sums so large rects never wrap
  assign w_din_coord  = din[COORD_WIDTH-1:0];
  assign w_sum_r      = {1'b0, r_left[w_back][r_rect]} + {1'b0, w_din_coord};
  assign w_sum_b      = {1'b0, r_top[w_back][r_rect]}  + {1'b0, w_din_coord};
  assign w_sat_right  = w_sum_r[COORD_WIDTH] ? '1 : w_sum_r[COORD_WIDTH-1:0];
  assign w_sat_bottom = w_sum_b[COORD_WIDTH] ? '1 : w_sum_b[COORD_WIDTH-1:0];

  // Record word write into the back bank field picked by the word counter
  always_ff @(posedge pixel_clk) begin
    if (w_wr_en) begin
      case (r_word)
        3'd0:    r_left[w_back][r_rect]   <= w_din_coord;
        3'd1:    r_top[w_back][r_rect]    <= w_din_coord;
        3'd2:    r_right[w_back][r_rect]  <= w_sat_right;
        3'd3:    r_bottom[w_back][r_rect] <= w_sat_bottom;
        default: r_cmem[w_back][r_rect]   <= din;
      endcase
    end
  end

  // Per-rect collision test against the rendered bank
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < RECT_COUNT; i++) begin
      w_hit[i] = r_bank_loaded[r_active] &&
                 (x_coord >= r_left[r_active][i])  && (x_coord < r_right[r_active][i]) &&
                 (y_coord >= r_top[r_active][i])   && (y_coord < r_bottom[r_active][i]);
    end
  end

  // Stage 1: capture hit vector with the bank it was computed against
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      r_hit_s1   <= '0;
      r_bank_s1  <= 1'b0;
      r_valid_s1 <= 1'b0;
    end else begin
      r_hit_s1   <= w_hit;
      r_bank_s1  <= r_active;
      r_valid_s1 <= coord_valid;
    end
  end

  // Highest covering index wins
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < RECT_COUNT; i++) begin
      if (r_hit_s1[i]) begin
        w_found = 1'b1;
        w_idx   = IDX_WIDTH'(i);
      end
    end
  end

  assign w_pix_color = w_found ? r_cmem[r_bank_s1][w_idx] : DEFAULT_COLOR;

  // Stage 2: registered pixel color and valid
  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      r_color       <= DEFAULT_COLOR;
      r_color_valid <= 1'b0;
    end else begin
      r_color       <= w_pix_color;
      r_color_valid <= r_valid_s1;
    end
  end

  assign color        = r_color;
  assign color_valid  = r_color_valid;
  assign busy         = w_busy;
  assign swap_pending = r_swap_pending;
  assign active_bank  = r_active;

endmodule
